// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared next-PC select encoding and alignment constant for the fetch PC slice
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_JR,
    SEL_RAS,
    SEL_EXC
  } pc_sel_e;

  // Instructions are word aligned; this many low PC bits are always zero.
  localparam int PC_ALIGN = 2;

endpackage

// File: rtl/pc_if.sv
// rtl/pc_if.sv - redirect/control bundle between decode/branch resolution and the fetch PC unit
interface pc_if #(
  parameter int WORD_SIZE = 32
);

  logic                 stall;
  logic                 br_taken;
  logic [WORD_SIZE-1:0] br_offset;
  logic                 jmp;
  logic [25:0]          jmp_index;
  logic                 jr;
  logic [WORD_SIZE-1:0] jr_target;
  logic                 exc;
  logic                 call;
  logic                 ret;
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] pc_plus4;
  logic                 misaligned;
  logic                 ras_hit;

  modport master (
    output stall, br_taken, br_offset, jmp, jmp_index, jr, jr_target, exc, call, ret,
    input  pc, pc_plus4, misaligned, ras_hit
  );

  modport slave (
    input  stall, br_taken, br_offset, jmp, jmp_index, jr, jr_target, exc, call, ret,
    output pc, pc_plus4, misaligned, ras_hit
  );

endinterface

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address LIFO; a push when full overwrites the oldest entry
module pc_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_top;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_top_inc;
  logic             w_pop;

  assign w_top_inc = r_top + PTR_W'(1);
  assign w_pop     = i_pop && !o_empty;
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_top     = r_mem[r_top];

  // Pointer wraps naturally (DEPTH is a power of two), so a full push lands on the oldest slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (i_push && w_pop) begin
      r_top   <= r_top;
      r_count <= r_count;
    end else if (i_push) begin
      r_top   <= w_top_inc;
      r_count <= o_full ? r_count : r_count + CNT_W'(1);
    end else if (w_pop) begin
      r_top   <= r_top - PTR_W'(1);
      r_count <= r_count - CNT_W'(1);
    end
  end

  // Simultaneous pop and push replaces the current top in place.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[w_pop ? r_top : w_top_inc] <= i_data;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - MIPS fetch PC register with prioritised next-PC select
// Define PC_RAS_EN to add the return-address stack (call/ret, ras_hit).
module pc_unit
  import pc_pkg::*;
#(
  parameter int                   WORD_SIZE    = 32,
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0,
  parameter logic [WORD_SIZE-1:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int                   RAS_DEPTH    = 4
) (
  input logic  clk,
  input logic  rst,
  pc_if.slave  bus
);

  logic [WORD_SIZE-1:0] r_pc;
  logic                 r_misaligned;
  logic [WORD_SIZE-1:0] w_pc_plus4;
  logic [WORD_SIZE-1:0] w_next_pc;
  logic [WORD_SIZE-1:0] w_ras_top;
  logic                 w_accept;
  logic                 w_ras_pop;
  pc_sel_e              w_sel;

  assign w_pc_plus4 = r_pc + WORD_SIZE'(4);
  assign w_accept   = !bus.exc && !bus.stall;

`ifdef PC_RAS_EN
  logic r_ras_hit;
  logic w_ras_push;
  logic w_ras_empty;
  logic w_ras_full;

  assign w_ras_pop  = w_accept && bus.jr && bus.ret && !w_ras_empty;
  assign w_ras_push = w_accept && bus.call && (bus.jmp || bus.jr);

  pc_ras #(
    .WIDTH (WORD_SIZE),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_ras_push),
    .i_pop   (w_ras_pop),
    .i_data  (w_pc_plus4),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty),
    .o_full  (w_ras_full)
  );

  wire w_unused_ok = w_ras_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ras_hit <= 1'b0;
    end else if (!bus.stall || bus.exc) begin
      r_ras_hit <= (w_sel == SEL_RAS);
    end
  end

  assign bus.ras_hit = r_ras_hit;
`else
  assign w_ras_pop   = 1'b0;
  assign w_ras_top   = '0;
  assign bus.ras_hit = 1'b0;

  wire w_unused_ok = &{1'b0, bus.call, bus.ret};
`endif

  // Stall is applied at the register enable, so select only ranks the redirect sources.
  always_comb begin
    w_sel = SEL_SEQ;
    if (bus.exc) begin
      w_sel = SEL_EXC;
    end else if (bus.jr) begin
      w_sel = w_ras_pop ? SEL_RAS : SEL_JR;
    end else if (bus.jmp) begin
      w_sel = SEL_JMP;
    end else if (bus.br_taken) begin
      w_sel = SEL_BR;
    end
  end

  always_comb begin
    w_next_pc = w_pc_plus4;
    case (w_sel)
      SEL_EXC: w_next_pc = EXC_VECTOR;
      SEL_RAS: w_next_pc = w_ras_top;
      SEL_JR:  w_next_pc = {bus.jr_target[WORD_SIZE-1:PC_ALIGN], {PC_ALIGN{1'b0}}};
      SEL_JMP: w_next_pc = {w_pc_plus4[WORD_SIZE-1:28], bus.jmp_index, {PC_ALIGN{1'b0}}};
      SEL_BR:  w_next_pc = w_pc_plus4 + (bus.br_offset << PC_ALIGN);
      default: w_next_pc = w_pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc         <= RESET_VECTOR;
      r_misaligned <= 1'b0;
    end else if (!bus.stall || bus.exc) begin
      r_pc         <= w_next_pc;
      r_misaligned <= (w_sel == SEL_JR) && (|bus.jr_target[PC_ALIGN-1:0]);
    end
  end

  assign bus.pc         = r_pc;
  assign bus.pc_plus4   = w_pc_plus4;
  assign bus.misaligned = r_misaligned;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
// RAS steps are compiled only when PC_RAS_EN is defined.
module tb_pc_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pc_if #(.WORD_SIZE(32)) bus ();

  pc_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.stall     = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_offset = '0;
    bus.jmp       = 1'b0;
    bus.jmp_index = '0;
    bus.jr        = 1'b0;
    bus.jr_target = '0;
    bus.exc       = 1'b0;
    bus.call      = 1'b0;
    bus.ret       = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic go_jr(input logic [31:0] tgt);
    clr();
    bus.jr        = 1'b1;
    bus.jr_target = tgt;
    step();
    clr();
  endtask

`ifdef PC_RAS_EN
  logic [31:0] ret_exp [4] = '{32'h0000_1004, 32'h0000_0C04, 32'h0000_0804, 32'h0000_0404};
`endif

  initial begin
    total = 0;
    bad   = 0;
    clr();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_pc", bus.pc, 32'h0);
    chk("reset_pc_plus4", bus.pc_plus4, 32'h4);
    chk("reset_misaligned", {31'b0, bus.misaligned}, 32'h0);
    chk("reset_ras_hit", {31'b0, bus.ras_hit}, 32'h0);
    rst = 1'b1;

    step(); chk("seq_1", bus.pc, 32'h4);
    step(); chk("seq_2", bus.pc, 32'h8);
    step(); chk("seq_3", bus.pc, 32'hC);
    step(); chk("seq_4", bus.pc, 32'h10);

    #2 rst = 1'b0;
    #1 chk("async_reset", bus.pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step(); chk("after_reset_release", bus.pc, 32'h4);

    go_jr(32'h10);
    chk("jr_to_10", bus.pc, 32'h10);
    bus.br_taken  = 1'b1;
    bus.br_offset = 32'hFFFF_FFFE;
    step(); chk("br_neg2", bus.pc, 32'h0C);
    go_jr(32'h10);
    bus.br_taken  = 1'b1;
    bus.br_offset = 32'h3;
    step(); chk("br_pos3", bus.pc, 32'h20);
    clr();

    go_jr(32'h3000_0000);
    bus.jmp       = 1'b1;
    bus.jmp_index = 26'h40;
    step(); chk("jmp_region", bus.pc, 32'h3000_0100);
    bus.jr        = 1'b1;
    bus.jr_target = 32'h2000;
    bus.br_taken  = 1'b1;
    bus.br_offset = 32'h7;
    step(); chk("jr_priority", bus.pc, 32'h2000);
    clr();

    go_jr(32'h1003);
    chk("jr_aligned", bus.pc, 32'h1000);
    chk("misaligned_set", {31'b0, bus.misaligned}, 32'h1);
    step();
    chk("misaligned_clear", {31'b0, bus.misaligned}, 32'h0);
    chk("seq_after_jr", bus.pc, 32'h1004);

    bus.stall     = 1'b1;
    bus.br_taken  = 1'b1;
    bus.br_offset = 32'h10;
    step(); chk("stall_1", bus.pc, 32'h1004);
    step(); chk("stall_2", bus.pc, 32'h1004);
    step(); chk("stall_3", bus.pc, 32'h1004);
    clr();
    go_jr(32'h2002);
    bus.stall = 1'b1;
    step(); chk("stall_holds_misaligned", {31'b0, bus.misaligned}, 32'h1);
    chk("stall_holds_pc", bus.pc, 32'h2000);
    bus.exc = 1'b1;
    step(); chk("stall_exc", bus.pc, 32'h8000_0180);
    chk("exc_clears_misaligned", {31'b0, bus.misaligned}, 32'h0);
    clr();

    go_jr(32'hFFFF_FFFC);
    chk("top_pc_plus4", bus.pc_plus4, 32'h0);
    step(); chk("wrap_to_zero", bus.pc, 32'h0);

`ifdef PC_RAS_EN
    go_jr(32'h100);
    bus.jmp = 1'b1; bus.call = 1'b1; bus.jmp_index = 26'h80;
    step(); chk("call_jmp", bus.pc, 32'h200);
    clr();
    bus.jr = 1'b1; bus.ret = 1'b1; bus.jr_target = 32'h0;
    step(); chk("ret_pc", bus.pc, 32'h104);
    chk("ret_ras_hit", {31'b0, bus.ras_hit}, 32'h1);
    clr();
    step(); chk("ras_hit_clear", {31'b0, bus.ras_hit}, 32'h0);
    bus.jr = 1'b1; bus.ret = 1'b1; bus.jr_target = 32'h40;
    step(); chk("ret_empty_pc", bus.pc, 32'h40);
    chk("ret_empty_hit", {31'b0, bus.ras_hit}, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      clr();
      bus.jmp = 1'b1; bus.call = 1'b1; bus.jmp_index = 26'(k * 32'h100);
      step(); chk("call_chain", bus.pc, 32'(k * 32'h400));
    end
    for (int k = 0; k < 4; k++) begin
      clr();
      bus.jr = 1'b1; bus.ret = 1'b1; bus.jr_target = 32'h0;
      step(); chk("ret_chain_pc", bus.pc, ret_exp[k]);
      chk("ret_chain_hit", {31'b0, bus.ras_hit}, 32'h1);
    end
    clr();
    bus.jr = 1'b1; bus.ret = 1'b1; bus.jr_target = 32'h2000;
    step(); chk("ret_after_drain", bus.pc, 32'h2000);
    chk("ret_after_drain_hit", {31'b0, bus.ras_hit}, 32'h0);
`else
    go_jr(32'h100);
    bus.jmp = 1'b1; bus.call = 1'b1; bus.jmp_index = 26'h80;
    step(); chk("noras_call", bus.pc, 32'h200);
    clr();
    bus.jr = 1'b1; bus.ret = 1'b1; bus.jr_target = 32'h300;
    step(); chk("noras_ret_uses_jr", bus.pc, 32'h300);
    chk("noras_ras_hit", {31'b0, bus.ras_hit}, 32'h0);
`endif
    clr();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
